// File: rtl/mio_bus_slave.sv
// Memory/IO bus responder: serves one CPU access at a time and routes it to
// external sync RAM, GPIO (LED/SW) or an internal reload timer with interrupt.
module mio_bus_slave #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_in,
  output logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic              INT
);

  localparam logic [31:0] A_LED  = 32'hE000_0000;
  localparam logic [31:0] A_SW   = 32'hE000_0004;
  localparam logic [31:0] A_TCNT = 32'hF000_0000;
  localparam logic [31:0] A_TCTL = 32'hF000_0004;
  localparam logic [31:0] A_TRLD = 32'hF000_0008;

  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, DONE, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [31:0] dout_q;
  logic        ready_q;
  logic [15:0] led_q;
  logic [31:0] tcnt_q, trld_q;
  logic        en_q, ie_q, pend_q, int_q;

  // decode works on the latched address only
  logic hit_ram, hit_led, hit_sw, hit_tcnt, hit_tctl, hit_trld;
  assign hit_ram  = (addr_q[31:RAM_AW+2] == '0);
  assign hit_led  = (addr_q == A_LED);
  assign hit_sw   = (addr_q == A_SW);
  assign hit_tcnt = (addr_q == A_TCNT);
  assign hit_tctl = (addr_q == A_TCTL);
  assign hit_trld = (addr_q == A_TRLD);

  logic in_access, reg_wr, reg_rd, wr_led, wr_tcnt, wr_tctl, wr_trld, tmr_zero;
  assign in_access = (state_q == ACCESS);
  assign reg_wr    = in_access &  we_q & ~hit_ram;
  assign reg_rd    = in_access & ~we_q & ~hit_ram;
  assign wr_led    = reg_wr & hit_led;
  assign wr_tcnt   = reg_wr & hit_tcnt;
  assign wr_tctl   = reg_wr & hit_tctl;
  assign wr_trld   = reg_wr & hit_trld;
  assign tmr_zero  = en_q & (tcnt_q == 32'd0);

  // RAM strobes come from registered state, so an async reset kills ram_we at once
  assign ram_we   = in_access & we_q & hit_ram;
  assign ram_addr = addr_q[RAM_AW+1:2];
  assign ram_din  = wdata_q;

  assign Data_out  = dout_q;
  assign MIO_ready = ready_q;
  assign led_out   = led_q;
  assign INT       = int_q;

  // register read mux; unmapped addresses read as zero
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (hit_led)       rdata = {16'h0, led_q};
    else if (hit_sw)   rdata = {16'h0, sw_in};
    else if (hit_tcnt) rdata = tcnt_q;
    else if (hit_tctl) rdata = {29'h0, pend_q, ie_q, en_q};
    else if (hit_trld) rdata = trld_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; HOLD absorbs a request that stays high after completion
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (CPU_MIO) state_d = ACCESS;
      ACCESS:  state_d = (hit_ram & ~we_q) ? CAPTURE : DONE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = CPU_MIO ? HOLD : IDLE;
      HOLD:    if (!CPU_MIO) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // request latch, taken once per access in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (state_q == IDLE && CPU_MIO) begin
      addr_q  <= Addr_in;
      wdata_q <= Data_in;
      we_q    <= mem_w;
    end
  end

  // read data and ready pulse; writes never touch Data_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_d == DONE);
      if (reg_rd)                  dout_q <= rdata;
      else if (state_q == CAPTURE) dout_q <= ram_dout;
    end
  end

  // LED register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        led_q <= '0;
    else if (wr_led) led_q <= wdata_q[15:0];
  end

  // reload timer: CPU write beats count/reload, set beats W1C, reload uses old TRLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
      trld_q <= '0;
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      if (wr_tcnt)   tcnt_q <= wdata_q;
      else if (en_q) tcnt_q <= (tcnt_q != 32'd0) ? tcnt_q - 32'd1 : trld_q;
      if (wr_trld) trld_q <= wdata_q;
      if (wr_tctl) begin
        en_q <= wdata_q[0];
        ie_q <= wdata_q[1];
      end
      if (tmr_zero)                  pend_q <= 1'b1;
      else if (wr_tctl & wdata_q[2]) pend_q <= 1'b0;
      int_q <= pend_q & ie_q;
    end
  end

endmodule

// File: tb/tb_mio_bus_slave.sv
// Bench for mio_bus_slave: transaction driver, behavioural register/RAM/timer
// model, and a per-cycle compare process.
module tb_mio_bus_slave;
  localparam int AW = 10;
  localparam logic [31:0] A_LED  = 32'hE000_0000;
  localparam logic [31:0] A_SW   = 32'hE000_0004;
  localparam logic [31:0] A_TCNT = 32'hF000_0000;
  localparam logic [31:0] A_TCTL = 32'hF000_0004;
  localparam logic [31:0] A_TRLD = 32'hF000_0008;

  logic          clk = 1'b0, rst = 1'b1, CPU_MIO = 1'b0, mem_w = 1'b0;
  logic [31:0]   Addr_in = '0, Data_in = '0, Data_out, ram_din, ram_dout;
  logic          MIO_ready, ram_we, INT;
  logic [AW-1:0] ram_addr;
  logic [15:0]   sw_in = '0, led_out;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mio_bus_slave #(.RAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_in(Addr_in), .Data_in(Data_in), .Data_out(Data_out),
    .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .sw_in(sw_in),
    .led_out(led_out), .INT(INT)
  );

  // external synchronous RAM
  logic [31:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic bit isram(input logic [31:0] a);
    return a < 32'(4 << AW);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) m_mem[i] = '0;
  logic [15:0] m_led;
  logic [31:0] m_tcnt, m_trld, m_dout;
  logic        m_en, m_ie, m_pend, m_int;
  // commit requests posted by the driver, applied at the access commit edge
  bit          c_wen = 0, c_ren = 0;
  logic [31:0] c_a = '0, c_d = '0;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (isram(a))    return m_mem[a[AW+1:2]];
    if (a == A_LED)  return {16'h0, m_led};
    if (a == A_SW)   return {16'h0, sw_in};
    if (a == A_TCNT) return m_tcnt;
    if (a == A_TCTL) return {29'h0, m_pend, m_ie, m_en};
    if (a == A_TRLD) return m_trld;
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_led <= '0; m_tcnt <= '0; m_trld <= '0; m_dout <= '0;
      m_en <= 0; m_ie <= 0; m_pend <= 0; m_int <= 0;
    end else begin
      m_tcnt <= (c_wen && c_a == A_TCNT) ? c_d :
                !m_en ? m_tcnt : (m_tcnt != 0) ? m_tcnt - 1 : m_trld;
      if (c_wen && c_a == A_TRLD) m_trld <= c_d;
      if (c_wen && c_a == A_TCTL) begin m_en <= c_d[0]; m_ie <= c_d[1]; end
      m_pend <= (m_en && m_tcnt == 0) ? 1'b1 :
                (c_wen && c_a == A_TCTL && c_d[2]) ? 1'b0 : m_pend;
      m_int  <= m_pend & m_ie;
      if (c_wen && c_a == A_LED) m_led <= c_d[15:0];
      if (c_wen && isram(c_a))   m_mem[c_a[AW+1:2]] <= c_d;
      if (c_ren) m_dout <= rd_val(c_a);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit            ready_due = 0, we_due = 0;
  logic [AW-1:0] exp_ra = '0;
  logic [31:0]   exp_din = '0;

  always @(negedge clk) if (rst) begin
    chk("ready", 32'(MIO_ready), 32'(ready_due));
    chk("ram_we", 32'(ram_we), 32'(we_due));
    if (we_due) begin
      chk("ram_addr", 32'(ram_addr), 32'(exp_ra));
      chk("ram_din", ram_din, exp_din);
    end
    if (ready_due) chk("rdata", Data_out, m_dout);
    chk("led", 32'(led_out), 32'(m_led));
    chk("INT", 32'(INT), 32'(m_int));
  end

  // one complete access; starts and ends in an IDLE cycle, just after an edge
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold);
    CPU_MIO = 1; mem_w = w; Addr_in = a; Data_in = d;
    @(posedge clk); #1;                       // ACCESS
    Addr_in = $urandom; Data_in = $urandom;   // bus no longer relevant
    we_due = w && isram(a); exp_ra = a[AW+1:2]; exp_din = d;
    c_wen = w; c_ren = !w; c_a = a; c_d = d;
    @(posedge clk); #1;
    c_wen = 0; c_ren = 0; we_due = 0;
    if (!w && isram(a)) begin @(posedge clk); #1; end  // RAM capture cycle
    ready_due = 1;
    if (hold == 0) CPU_MIO = 0;
    @(posedge clk); #1;
    ready_due = 0;
    for (int h = 1; h <= hold; h++) begin
      if (h == hold) CPU_MIO = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_int(input logic v, input int maxc);
    for (int i = 0; i < maxc && INT !== v; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    bit w;
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("rst_dout", Data_out, 32'h0);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_int", 32'(INT), 32'h0);
    chk("rst_ready", 32'(MIO_ready), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_raddr", 32'(ram_addr), 32'h0);
    repeat (20) @(posedge clk);
    #1;

    // RAM write/read
    access(1, 32'h10, 32'hDEADBEEF, 0);
    access(0, 32'h10, 32'h0, 0);
    chk("ram_rd_lit", Data_out, 32'hDEADBEEF);
    // GPIO and unmapped
    access(1, A_LED, 32'h1234ABCD, 0);
    chk("led_lit", 32'(led_out), 32'h0000ABCD);
    sw_in = 16'h5A5A;
    access(0, A_SW, 32'h0, 0);
    chk("sw_lit", Data_out, 32'h00005A5A);
    access(0, 32'h9000_0000, 32'h0, 0);
    chk("unmapped_lit", Data_out, 32'h0);
    access(1, 32'h4, 32'h0BAD_F00D, 0);
    chk("wr_keeps_dout", Data_out, 32'h0);

    // timer: first underflow, W1C clear, next underflow
    access(1, A_TRLD, 32'd3, 0);
    access(1, A_TCNT, 32'd2, 0);
    access(1, A_TCTL, 32'b011, 0);
    wait_int(1'b1, 20);
    chk("int_rise", 32'(INT), 32'h1);
    access(1, A_TCTL, 32'b111, 0);
    chk("int_drop", 32'(INT), 32'h0);
    wait_int(1'b1, 20);
    chk("int_rerise", 32'(INT), 32'h1);
    access(1, A_TCTL, 32'b100, 0);

    // held requests complete exactly once
    access(1, A_LED, 32'h1, 6);
    chk("held_led_lit", 32'(led_out), 32'h1);
    access(1, 32'h40, 32'h1111_2222, 3);
    access(0, 32'h40, 32'h0, 2);
    chk("held_ram_lit", Data_out, 32'h1111_2222);

    // reset in the ACCESS cycle of a RAM write
    CPU_MIO = 1; mem_w = 1; Addr_in = 32'h20; Data_in = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("we_pre_rst", 32'(ram_we), 32'h1);
    rst = 0; CPU_MIO = 0;
    #1;
    chk("we_post_rst", 32'(ram_we), 32'h0);
    chk("ready_post_rst", 32'(MIO_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (5) @(posedge clk);
    #1;
    access(0, 32'h20, 32'h0, 0);
    chk("rst_no_write", Data_out, 32'h0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      case ($urandom_range(0, 8))
        0, 1:    a = 32'($urandom_range(0, 15)) << 2;
        2:       a = 32'hFFC;
        3:       a = A_LED;
        4:       a = A_SW;
        5:       a = A_TCNT;
        6:       a = A_TCTL;
        7:       a = A_TRLD;
        default: case ($urandom_range(0, 3))
                   0: a = 32'h1000;
                   1: a = 32'hE000_0008;
                   2: a = 32'hF000_000C;
                   default: a = 32'h9000_0000;
                 endcase
      endcase
      if (a == A_TCNT || a == A_TRLD) d = 32'($urandom_range(0, 12));
      sw_in = 16'($urandom);
      access(w, a, d, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
